memoria32_data: RTL and testbench

- Word-organised 32-bit data RAM with four independent byte lanes, separate read and write byte addresses, and a per-lane write mask.
- Backing store for the pipeline's data-memory wrapper. The wrapper performs load sign/zero extension and store lane steering, then drives this block with the inverted system clock, so writes land mid-cycle.
- Reads are combinational. Writes and reset are synchronous to Clk.

---
 rtl/memoria32_data_pkg.sv | 14 +
 rtl/memoria32_data_lane.sv | 34 +++
 rtl/memoria32_data.sv | 39 +++
 tb/tb_memoria32_data.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/memoria32_data_pkg.sv
// Shared constants, lane-mask type and address helper for the 32-bit data RAM.
package memoria32_data_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;

  typedef logic [LANES-1:0] lane_mask_t;

  // Drops the byte offset; the caller truncates to its own word-index width.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/memoria32_data_lane.sv
// One 8-bit lane of the data RAM: combinational read, gated synchronous write,
// synchronous active-low clear of every entry.
module memoria32_data_lane
  import memoria32_data_pkg::*;
#(
  parameter int unsigned WORD_ADDR_W = 7
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [WORD_ADDR_W-1:0] raddr_i,
  input  logic [WORD_ADDR_W-1:0] waddr_i,
  input  logic [LANE_W-1:0]      wdata_i,
  input  logic                   we_i,
  output logic [LANE_W-1:0]      rdata_o
);

  localparam int unsigned DEPTH = 1 << WORD_ADDR_W;

  logic [LANE_W-1:0] mem_q [DEPTH];

  // Clear wins over a simultaneous write.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/memoria32_data.sv
// Word-organised 32-bit data RAM built from four byte lanes; lane 3 holds byte
// offset 0, reads are combinational and writes/clear are synchronous to Clk.
module memoria32_data
  import memoria32_data_pkg::*;
#(
  parameter int unsigned WORD_ADDR_W = 7,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [31:0]       raddress,
  input  logic [31:0]       waddress,
  input  logic [DATA_W-1:0] Datain,
  input  lane_mask_t        Wr,
  output logic [DATA_W-1:0] Dataout
);

  logic [WORD_ADDR_W-1:0] rword;
  logic [WORD_ADDR_W-1:0] wword;

  // Upper address bits are discarded so accesses wrap modulo the depth.
  assign rword = WORD_ADDR_W'(word_index(raddress));
  assign wword = WORD_ADDR_W'(word_index(waddress));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    memoria32_data_lane #(
      .WORD_ADDR_W(WORD_ADDR_W)
    ) u_lane (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .raddr_i (rword),
      .waddr_i (wword),
      .wdata_i (Datain[g*LANE_W +: LANE_W]),
      .we_i    (Wr[g]),
      .rdata_o (Dataout[g*LANE_W +: LANE_W])
    );
  end

endmodule

// File: tb/tb_memoria32_data.sv
// Self-checking bench for memoria32_data: directed scenarios plus randomized
// traffic checked against a byte-array reference model.
module tb_memoria32_data;

  logic        Clk;
  logic        Reset_n;
  logic [31:0] raddress;
  logic [31:0] waddress;
  logic [31:0] Datain;
  logic [3:0]  Wr;
  logic [31:0] Dataout;

  int tests;
  int fails;

  // Reference memory kept as bytes in address order: byte offset 0 is the
  // most significant byte of the word as read out.
  logic [7:0] ref_bytes [512];

  memoria32_data dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .raddress (raddress),
    .waddress (waddress),
    .Datain   (Datain),
    .Wr       (Wr),
    .Dataout  (Dataout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    int base;
    base = int'(addr % 512) & ~3;
    return {ref_bytes[base], ref_bytes[base+1], ref_bytes[base+2], ref_bytes[base+3]};
  endfunction

  // One clock edge with the given controls, then update the model the way
  // the memory is described: reset clears everything, else masked bytes land.
  task automatic edge_op(input logic rst_n, input logic [31:0] wa,
                         input logic [31:0] d, input logic [3:0] w);
    int base;
    @(negedge Clk);
    Reset_n  = rst_n;
    waddress = wa;
    Datain   = d;
    Wr       = w;
    @(posedge Clk);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) ref_bytes[i] = 8'h00;
    end else begin
      base = int'(wa % 512) & ~3;
      for (int off = 0; off < 4; off++) begin
        if (w[3-off]) ref_bytes[base+off] = d[31-8*off -: 8];
      end
    end
    Reset_n = 1'b1;
    Wr      = 4'h0;
  endtask

  task automatic test_reset();
    edge_op(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    raddress = 32'h10; #1;
    tests++;
    if (Dataout !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL reset_prewrite: got %h want %h", Dataout, 32'hDEAD_BEEF);
    end
    edge_op(1'b0, 32'h0, 32'h0, 4'h0);
    raddress = 32'h10; #1;
    tests++;
    if (Dataout !== 32'h0) begin
      fails++; $display("FAIL reset_clear: got %h want %h", Dataout, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      raddress = $urandom; #1;
      tests++;
      if (Dataout !== 32'h0) begin
        fails++; $display("FAIL reset_any_addr %h: got %h want 0", raddress, Dataout);
      end
    end
  endtask

  task automatic test_full_word();
    logic [31:0] ra [3];
    ra[0] = 32'h08; ra[1] = 32'h09; ra[2] = 32'h0B;
    edge_op(1'b1, 32'h08, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 3; i++) begin
      raddress = ra[i]; #1;
      tests++;
      if (Dataout !== 32'h1234_5678) begin
        fails++; $display("FAIL full_word ra=%h: got %h want %h", ra[i], Dataout, 32'h1234_5678);
      end
    end
  endtask

  task automatic test_lane_merge();
    raddress = 32'h20;
    edge_op(1'b1, 32'h20, 32'h1122_3344, 4'hF);
    edge_op(1'b1, 32'h20, 32'h00AB_0000, 4'b0100);
    tests++;
    if (Dataout !== 32'h11AB_3344) begin
      fails++; $display("FAIL lane_merge_1: got %h want %h", Dataout, 32'h11AB_3344);
    end
    edge_op(1'b1, 32'h20, 32'h0000_00CD, 4'b0001);
    tests++;
    if (Dataout !== 32'h11AB_33CD) begin
      fails++; $display("FAIL lane_merge_2: got %h want %h", Dataout, 32'h11AB_33CD);
    end
  endtask

  task automatic test_halfword();
    edge_op(1'b0, 32'h0, 32'h0, 4'h0);
    raddress = 32'h40;
    edge_op(1'b1, 32'h40, 32'hBEEF_0000, 4'b1100);
    tests++;
    if (Dataout !== 32'hBEEF_0000) begin
      fails++; $display("FAIL halfword_hi: got %h want %h", Dataout, 32'hBEEF_0000);
    end
    edge_op(1'b1, 32'h40, 32'h0000_CAFE, 4'b0011);
    tests++;
    if (Dataout !== 32'hBEEF_CAFE) begin
      fails++; $display("FAIL halfword_lo: got %h want %h", Dataout, 32'hBEEF_CAFE);
    end
  endtask

  task automatic test_priority_noop();
    raddress = 32'h0;
    edge_op(1'b1, 32'h0, 32'h1357_9BDF, 4'hF);
    edge_op(1'b0, 32'h0, 32'hFFFF_FFFF, 4'hF);
    tests++;
    if (Dataout !== 32'h0) begin
      fails++; $display("FAIL reset_priority: got %h want %h", Dataout, 32'h0);
    end
    edge_op(1'b1, 32'h0, 32'h5555_5555, 4'h0);
    tests++;
    if (Dataout !== 32'h0) begin
      fails++; $display("FAIL noop_write: got %h want %h", Dataout, 32'h0);
    end
  endtask

  task automatic test_wrap_comb_read();
    edge_op(1'b1, 32'h200, 32'hA5A5_A5A5, 4'hF);
    edge_op(1'b1, 32'h104, 32'h0F0F_1E1E, 4'hF);
    raddress = 32'h000; #1;
    tests++;
    if (Dataout !== 32'hA5A5_A5A5) begin
      fails++; $display("FAIL wrap_read: got %h want %h", Dataout, 32'hA5A5_A5A5);
    end
    // Same clock phase, no edge between these reads.
    raddress = 32'h104; #1;
    tests++;
    if (Dataout !== 32'h0F0F_1E1E) begin
      fails++; $display("FAIL comb_read_a: got %h want %h", Dataout, 32'h0F0F_1E1E);
    end
    raddress = 32'h8000_0000; #1;
    tests++;
    if (Dataout !== 32'hA5A5_A5A5) begin
      fails++; $display("FAIL comb_read_high_bits: got %h want %h", Dataout, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_random();
    logic [31:0] wa, d, exp;
    logic [3:0]  w;
    logic        rst_n;
    edge_op(1'b0, 32'h0, 32'h0, 4'h0);
    for (int n = 0; n < 300; n++) begin
      wa    = $urandom;
      d     = $urandom;
      w     = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 39) != 0);
      // Watch the target word across the edge: old before, merged after.
      @(negedge Clk);
      raddress = wa ^ 32'($urandom_range(0, 3));
      Reset_n  = rst_n;
      waddress = wa;
      Datain   = d;
      Wr       = w;
      #1;
      exp = ref_read(raddress);
      tests++;
      if (Dataout !== exp) begin
        fails++; $display("FAIL rand_before_edge n=%0d: got %h want %h", n, Dataout, exp);
      end
      edge_op(rst_n, wa, d, w);
      exp = ref_read(raddress);
      tests++;
      if (Dataout !== exp) begin
        fails++; $display("FAIL rand_after_edge n=%0d: got %h want %h", n, Dataout, exp);
      end
      raddress = $urandom; #1;
      exp = ref_read(raddress);
      tests++;
      if (Dataout !== exp) begin
        fails++; $display("FAIL rand_other n=%0d ra=%h: got %h want %h", n, raddress, Dataout, exp);
      end
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    Reset_n  = 1'b1;
    raddress = 32'h0;
    waddress = 32'h0;
    Datain   = 32'h0;
    Wr       = 4'h0;
    for (int i = 0; i < 512; i++) ref_bytes[i] = 8'hxx;
    repeat (2) @(posedge Clk);
    test_reset();
    test_full_word();
    test_lane_merge();
    test_halfword();
    test_priority_noop();
    test_wrap_comb_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
